// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a req/rdy handshake to instruction memory,
// and presents one instruction at a time to IF_ID, honouring stalls, redirects and HALT.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WEN,
  input  logic        Redirect_ex,
  input  logic [31:0] RedirectPC_ex,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_if,
  output logic [31:0] Inst_if,
  output logic        valid_if,
  output logic        halt_if
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_r;
  logic [31:0] pend_r;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic        hold_valid;
  logic        hold_halt;

  // State updates on the falling edge so this stage lines up with the pipeline registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) state <= FETCH;
    else      state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (imem_rdy)         state_nxt = Redirect_ex ? FETCH : HOLD;
        else if (Redirect_ex) state_nxt = SQUASH;
      end
      SQUASH: begin
        if (imem_rdy) state_nxt = FETCH;
      end
      HOLD: begin
        if (Redirect_ex) state_nxt = FETCH;
        else if (!WEN)   state_nxt = hold_halt ? HALTED : FETCH;
      end
      HALTED: begin
        if (Redirect_ex) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      pc_r       <= RESET_PC;
      pend_r     <= 32'h0;
      hold_pc    <= 32'h0;
      hold_inst  <= 32'h0;
      hold_valid <= 1'b0;
      hold_halt  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_rdy && Redirect_ex) begin
            pc_r <= RedirectPC_ex;
          end else if (Redirect_ex) begin
            pend_r <= RedirectPC_ex;
          end else if (imem_rdy) begin
            hold_pc    <= pc_r;
            hold_inst  <= imem_rdata;
            hold_valid <= 1'b1;
            hold_halt  <= (imem_rdata == HALT_INST);
            pc_r       <= pc_r + 32'd4;
          end
        end
        SQUASH: begin
          // The outstanding word belongs to the wrong path; the newest redirect target wins.
          if (imem_rdy)         pc_r   <= Redirect_ex ? RedirectPC_ex : pend_r;
          else if (Redirect_ex) pend_r <= RedirectPC_ex;
        end
        HOLD: begin
          if (Redirect_ex) begin
            hold_valid <= 1'b0;
            pc_r       <= RedirectPC_ex;
          end else if (!WEN) begin
            hold_valid <= 1'b0;
          end
        end
        HALTED: begin
          if (Redirect_ex) pc_r <= RedirectPC_ex;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    imem_req  = (state == FETCH) || (state == SQUASH);
    imem_addr = pc_r;
    PC_if     = hold_pc;
    Inst_if   = hold_inst;
    // Redirect kills the presented word combinationally so IF_ID captures a bubble on that edge.
    valid_if  = hold_valid & ~Redirect_ex;
    halt_if   = hold_halt & valid_if;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: behavioural memory with programmable latency,
// a step-vector table for the streaming case, and hand-written corner sequences.
module tb_if_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        WEN;
  logic        Redirect_ex;
  logic [31:0] RedirectPC_ex;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rdata;
  logic [31:0] PC_if;
  logic [31:0] Inst_if;
  logic        valid_if;
  logic        halt_if;

  if_fetch_unit #(.RESET_PC(32'h0), .HALT_INST(32'h0)) dut (
    .CLK(CLK), .RST(RST), .WEN(WEN), .Redirect_ex(Redirect_ex), .RedirectPC_ex(RedirectPC_ex),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
    .PC_if(PC_if), .Inst_if(Inst_if), .valid_if(valid_if), .halt_if(halt_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        wen;
    logic        red;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_halt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        halt;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem [0:127];
  int          lat;
  int          cnt;
  logic [31:0] txn_addr;
  exp_t        sb[$];
  vec_t        vecs[6];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (a < 32'd512) return mem[a[8:2]];
    return ~a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic halt);
    exp_t e;
    e.pc = pc; e.inst = inst; e.halt = halt;
    return e;
  endfunction

  // One cycle: drive controls and the memory response after the rising edge, then look at
  // the DUT #1 later; a consumed word (valid & !WEN) is checked against the scoreboard.
  task automatic step(input logic w, input logic r, input logic [31:0] rp);
    exp_t e;
    @(posedge CLK);
    WEN = w; Redirect_ex = r; RedirectPC_ex = rp;
    if (!RST) begin
      cnt = 0; imem_rdy = 1'b0;
    end else if (imem_req) begin
      if (cnt > 0) check("addr_stable", imem_addr, txn_addr);
      txn_addr = imem_addr;
      if (cnt + 1 >= lat) begin
        imem_rdy = 1'b1; imem_rdata = rd(imem_addr); cnt = 0;
      end else begin
        imem_rdy = 1'b0; imem_rdata = 32'hDEAD_BEEF; cnt++;
      end
    end else begin
      imem_rdy = 1'b0; imem_rdata = 32'hDEAD_BEEF; cnt = 0;
    end
    #1;
    if (valid_if && !WEN) begin
      if (sb.size() == 0) begin
        check("unexpected_consume_pc", PC_if, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("sb_pc", PC_if, e.pc);
        check("sb_inst", Inst_if, e.inst);
        check("sb_halt", {31'h0, halt_if}, {31'h0, e.halt});
      end
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    do begin
      step(1'b1, 1'b0, 32'h0);
      n++;
    end while (!valid_if && n < budget);
    check("wait_valid", {31'h0, valid_if}, 32'h1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_pc"}, PC_if, 32'h0);
    check({tag, "_inst"}, Inst_if, 32'h0);
    check({tag, "_valid"}, {31'h0, valid_if}, 32'h0);
    check({tag, "_halt"}, {31'h0, halt_if}, 32'h0);
    check({tag, "_addr"}, imem_addr, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = i + 1;
    vecs[0] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h4, 1'b1, 32'h0, 32'h1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h8, 1'b1, 32'h4, 32'h2, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 32'h4, 32'h2, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'hC, 1'b1, 32'h8, 32'h3, 1'b0};

    RST = 1'b0; WEN = 1'b0; Redirect_ex = 1'b0; RedirectPC_ex = 32'h0;
    imem_rdy = 1'b0; imem_rdata = 32'h0; lat = 1; cnt = 0; txn_addr = 32'h0;
    repeat (2) @(posedge CLK);
    #2;
    check_zero_outputs("reset");
    RST = 1'b1;

    // Streaming with rdy every request cycle.
    sb.push_back(mk(32'h0, 32'h1, 1'b0));
    sb.push_back(mk(32'h4, 32'h2, 1'b0));
    sb.push_back(mk(32'h8, 32'h3, 1'b0));
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].wen, vecs[i].red, vecs[i].rpc);
      check($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].exp_req});
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_valid", i), {31'h0, valid_if}, {31'h0, vecs[i].exp_valid});
      check($sformatf("v%0d_pc", i), PC_if, vecs[i].exp_pc);
      check($sformatf("v%0d_inst", i), Inst_if, vecs[i].exp_inst);
      check($sformatf("v%0d_halt", i), {31'h0, halt_if}, {31'h0, vecs[i].exp_halt});
    end

    // Two-cycle memory, stalled in HOLD for three cycles.
    lat = 2;
    wait_valid(8);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0);
      check("stall_pc", PC_if, 32'hC);
      check("stall_inst", Inst_if, 32'h4);
      check("stall_valid", {31'h0, valid_if}, 32'h1);
      check("stall_req", {31'h0, imem_req}, 32'h0);
    end
    sb.push_back(mk(32'hC, 32'h4, 1'b0));
    step(1'b0, 1'b0, 32'h0);

    // Redirect while a fetch is outstanding; a second redirect during squash wins.
    lat = 4;
    step(1'b1, 1'b0, 32'h0);
    check("sq_req", {31'h0, imem_req}, 32'h1);
    check("sq_addr0", imem_addr, 32'h10);
    step(1'b1, 1'b1, 32'h80);
    check("sq_valid0", {31'h0, valid_if}, 32'h0);
    step(1'b1, 1'b1, 32'h100);
    check("sq_valid1", {31'h0, valid_if}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("sq_addr_held", imem_addr, 32'h10);
    lat = 1;
    step(1'b1, 1'b0, 32'h0);
    check("sq_new_addr", imem_addr, 32'h100);
    step(1'b1, 1'b0, 32'h0);
    check("sq_new_valid", {31'h0, valid_if}, 32'h1);
    check("sq_new_pc", PC_if, 32'h100);
    sb.push_back(mk(32'h100, rd(32'h100), 1'b0));
    step(1'b0, 1'b0, 32'h0);

    // Redirect while holding a stalled word.
    wait_valid(8);
    check("hold_pc", PC_if, 32'h104);
    step(1'b1, 1'b1, 32'h40);
    check("kill_valid", {31'h0, valid_if}, 32'h0);
    check("kill_halt", {31'h0, halt_if}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("kill_addr", imem_addr, 32'h40);
    check("kill_valid2", {31'h0, valid_if}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("kill_new_pc", PC_if, 32'h40);
    sb.push_back(mk(32'h40, rd(32'h40), 1'b0));
    step(1'b0, 1'b0, 32'h0);

    // HALT at 0x8, then a wrong-path redirect out of HALTED.
    mem[2] = 32'h0;
    step(1'b1, 1'b1, 32'h8);
    check("h_redir_addr", imem_addr, 32'h44);
    step(1'b1, 1'b0, 32'h0);
    check("h_addr", imem_addr, 32'h8);
    step(1'b1, 1'b0, 32'h0);
    check("h_halt", {31'h0, halt_if}, 32'h1);
    check("h_pc", PC_if, 32'h8);
    sb.push_back(mk(32'h8, 32'h0, 1'b1));
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0);
      check("halted_req", {31'h0, imem_req}, 32'h0);
      check("halted_valid", {31'h0, valid_if}, 32'h0);
    end
    step(1'b0, 1'b1, 32'h20);
    step(1'b1, 1'b0, 32'h0);
    check("resume_req", {31'h0, imem_req}, 32'h1);
    check("resume_addr", imem_addr, 32'h20);
    step(1'b1, 1'b0, 32'h0);
    sb.push_back(mk(32'h20, rd(32'h20), 1'b0));
    step(1'b0, 1'b0, 32'h0);

    // Reset in the middle of a slow transaction.
    lat = 4;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    #1;
    RST = 1'b0; imem_rdy = 1'b0; cnt = 0;
    #1;
    check_zero_outputs("midreset");
    @(posedge CLK);
    #2;
    RST = 1'b1; lat = 1;
    wait_valid(8);
    check("rst_pc", PC_if, 32'h0);
    sb.push_back(mk(32'h0, 32'h1, 1'b0));
    step(1'b0, 1'b0, 32'h0);

    // Fetch at the top of the address space wraps the PC.
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);
    check("wrap_inst", Inst_if, 32'h3);
    sb.push_back(mk(32'hFFFF_FFFC, 32'h3, 1'b0));
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);

    check("sb_empty", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
